// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit -- multi-cycle signed integer divider (restoring, one bit per clock)
//
// Responder side of the control unit's div_start/div_done handshake. A request
// taken in IDLE latches operand magnitudes and signs, runs WIDTH shift-subtract
// iterations in CALC (MSB first), then applies signs in FIX and raises div_done
// for one cycle. A zero divisor is answered at once with div_zero/div_done and
// leaves hi/lo untouched.
//
// Ports:
//   clock      in   single clock, rising edge
//   reset      in   asynchronous, active-low reset
//   div_start  in   request, only looked at in IDLE
//   dividend   in   WIDTH signed numerator, sampled with div_start
//   divisor    in   WIDTH signed denominator, sampled with div_start
//   div_busy   out  high while an operation is in progress
//   div_done   out  one-cycle completion pulse
//   div_zero   out  divide-by-zero flag, held until the next accepted request
//   hi         out  WIDTH remainder (carries the dividend's sign)
//   lo         out  WIDTH quotient (truncated toward zero)
// -----------------------------------------------------------------------------
module div_unit #(
  parameter int WIDTH  = 32,
  parameter int STEP_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             div_start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             div_busy,
  output logic             div_done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  localparam logic [STEP_W-1:0] CNT_ONE  = STEP_W'(1);
  localparam logic [STEP_W-1:0] CNT_LAST = STEP_W'(WIDTH - 1);

  logic [1:0]        state_q, state_d;
  logic [STEP_W-1:0] cnt_q, cnt_d;
  // Magnitudes are WIDTH+1 bits so that |-2^(WIDTH-1)| is representable.
  logic [WIDTH:0]    dvd_q, dvd_d;   // dividend magnitude; quotient bits shift in at LSB
  logic [WIDTH:0]    dvs_q, dvs_d;   // divisor magnitude
  logic [WIDTH:0]    rem_q, rem_d;   // partial remainder
  logic              sgn_dvd_q, sgn_dvd_d;
  logic              sgn_dvs_q, sgn_dvs_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              zero_q, zero_d;
  logic [WIDTH-1:0]  hi_q, hi_d;
  logic [WIDTH-1:0]  lo_q, lo_d;

  logic [WIDTH:0]    dvd_ext, dvs_ext;
  logic [WIDTH:0]    dvd_mag, dvs_mag;
  logic [WIDTH:0]    rem_shift;
  logic              sub_ok;
  logic [WIDTH-1:0]  quo_mag, rem_mag;

  // Datapath helpers shared by the state machine.
  always_comb begin
    dvd_ext   = {dividend[WIDTH-1], dividend};
    dvs_ext   = {divisor[WIDTH-1], divisor};
    dvd_mag   = dividend[WIDTH-1] ? -dvd_ext : dvd_ext;
    dvs_mag   = divisor[WIDTH-1]  ? -dvs_ext : dvs_ext;
    // Remainder stays below the divisor (<= 2^(WIDTH-1)), so its top bit is
    // always clear and the shifted value still fits in WIDTH+1 bits.
    rem_shift = {rem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
    sub_ok    = (rem_shift >= dvs_q);
    quo_mag   = dvd_q[WIDTH-1:0];
    rem_mag   = rem_q[WIDTH-1:0];
  end

  always_comb begin
    // NOTE: every variable gets a hold/default value first so no path through
    // the case statement leaves one unassigned (which would infer a latch).
    state_d   = state_q;
    cnt_d     = cnt_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    sgn_dvd_d = sgn_dvd_q;
    sgn_dvs_d = sgn_dvs_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    zero_d    = zero_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    case (state_q)
      IDLE: begin
        if (div_start) begin
          if (divisor == '0) begin
            zero_d = 1'b1;
            done_d = 1'b1;
          end else begin
            dvd_d     = dvd_mag;
            dvs_d     = dvs_mag;
            sgn_dvd_d = dividend[WIDTH-1];
            sgn_dvs_d = divisor[WIDTH-1];
            rem_d     = '0;
            cnt_d     = '0;
            busy_d    = 1'b1;
            zero_d    = 1'b0;
            state_d   = CALC;
          end
        end
      end
      CALC: begin
        rem_d = sub_ok ? (rem_shift - dvs_q) : rem_shift;
        dvd_d = {dvd_q[WIDTH-1:0], sub_ok};
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          state_d = FIX;
        end
      end
      FIX: begin
        // Truncating division: quotient negative iff signs differ, remainder
        // follows the dividend. -2^(WIDTH-1)/-1 simply wraps.
        lo_d    = (sgn_dvd_q ^ sgn_dvs_q) ? -quo_mag : quo_mag;
        hi_d    = sgn_dvd_q ? -rem_mag : rem_mag;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // NOTE: the working registers are reset along with the control state even
  // though CALC never reads them before IDLE reloads them; this keeps every
  // flop at a known value after reset and costs nothing functionally.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      sgn_dvd_q <= 1'b0;
      sgn_dvs_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      zero_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments so all flops update from the values
      // present before the edge, independent of statement order.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      rem_q     <= rem_d;
      sgn_dvd_q <= sgn_dvd_d;
      sgn_dvs_q <= sgn_dvs_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      zero_q    <= zero_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign div_busy = busy_q;
  assign div_done = done_q;
  assign div_zero = zero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_div_unit.sv
// -----------------------------------------------------------------------------
// tb_div_unit -- self-checking bench for div_unit (WIDTH=32).
// Reference results come from plain 64-bit signed / and %, which truncate
// toward zero with the remainder taking the dividend's sign.
// -----------------------------------------------------------------------------
module tb_div_unit;

  localparam int WIDTH   = 32;
  localparam int LATENCY = 33;

  logic             clock = 1'b0;
  logic             reset;
  logic             div_start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             div_busy;
  logic             div_done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  int total = 0;
  int bad   = 0;

  // Last successfully completed result, as predicted by the reference model.
  logic [WIDTH-1:0] exp_lo = '0;
  logic [WIDTH-1:0] exp_hi = '0;

  always #5 clock = ~clock;

  div_unit #(.WIDTH(WIDTH), .STEP_W(6)) dut (
    .clock     (clock),
    .reset     (reset),
    .div_start (div_start),
    .dividend  (dividend),
    .divisor   (divisor),
    .div_busy  (div_busy),
    .div_done  (div_done),
    .div_zero  (div_zero),
    .hi        (hi),
    .lo        (lo)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                output logic [WIDTH-1:0] q, output logic [WIDTH-1:0] r);
    longint sa, sb, lq, lr;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    lq = sa / sb;
    lr = sa % sb;
    q  = 32'(lq);
    r  = 32'(lr);
  endfunction

  // Present a request for one edge; returns #1 after the sampling edge with
  // the operand buses scrambled so any resampling would corrupt the result.
  task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    div_start = 1'b1;
    dividend  = a;
    divisor   = b;
    @(posedge clock);
    #1;
    div_start = 1'b0;
    dividend  = $urandom;
    divisor   = $urandom;
  endtask

  // Count edges until div_done is seen (bounded).
  task automatic wait_done(output int edges);
    edges = 0;
    while (div_done !== 1'b1 && edges < 200) begin
      @(posedge clock);
      #1;
      edges++;
    end
  endtask

  task automatic run_div(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input string tag);
    logic [WIDTH-1:0] mq, mr;
    int e;
    start_op(a, b);
    if (b == '0) begin
      check({tag, " zdone"}, div_done, 1);
      check({tag, " zflag"}, div_zero, 1);
      check({tag, " zbusy"}, div_busy, 0);
      check({tag, " zlo"}, lo, exp_lo);
      check({tag, " zhi"}, hi, exp_hi);
      @(posedge clock);
      #1;
      check({tag, " zdone_pulse"}, div_done, 0);
      check({tag, " zflag_hold"}, div_zero, 1);
      check({tag, " zbusy2"}, div_busy, 0);
    end else begin
      check({tag, " busy"}, div_busy, 1);
      check({tag, " zero_clr"}, div_zero, 0);
      wait_done(e);
      check({tag, " latency"}, e, LATENCY);
      model(a, b, mq, mr);
      check({tag, " lo"}, lo, mq);
      check({tag, " hi"}, hi, mr);
      check({tag, " busy_end"}, div_busy, 0);
      check({tag, " zero"}, div_zero, 0);
      exp_lo = mq;
      exp_hi = mr;
      @(posedge clock);
      #1;
      check({tag, " done_pulse"}, div_done, 0);
      check({tag, " lo_hold"}, lo, exp_lo);
      check({tag, " hi_hold"}, hi, exp_hi);
    end
  endtask

  initial begin
    int e;
    logic [WIDTH-1:0] ra, rb;

    div_start = 1'b0;
    dividend  = '0;
    divisor   = '0;
    reset     = 1'b1;

    // Asynchronous reset before any clock edge.
    #1 reset = 1'b0;
    #1;
    check("rst busy", div_busy, 0);
    check("rst done", div_done, 0);
    check("rst zero", div_zero, 0);
    check("rst hi", hi, 0);
    check("rst lo", lo, 0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;

    // Directed values with independently known answers.
    run_div(32'd7, 32'd2, "7/2");
    check("7/2 lo const", lo, 32'd3);
    check("7/2 hi const", hi, 32'd1);
    run_div(-32'sd7, 32'd2, "-7/2");
    check("-7/2 lo const", lo, 32'hFFFF_FFFD);
    check("-7/2 hi const", hi, 32'hFFFF_FFFF);
    run_div(32'd7, -32'sd2, "7/-2");
    check("7/-2 lo const", lo, 32'hFFFF_FFFD);
    check("7/-2 hi const", hi, 32'd1);

    // Divide by zero keeps prior results and sets the sticky flag.
    run_div(32'd5, 32'd0, "5/0");
    run_div(32'h8000_0000, 32'hFFFF_FFFF, "min/-1");
    check("min/-1 lo const", lo, 32'h8000_0000);
    check("min/-1 hi const", hi, 32'd0);

    // Start ignored while busy, then a start accepted in the done cycle.
    start_op(32'd100, 32'd7);
    repeat (10) begin
      @(posedge clock);
      #1;
    end
    div_start = 1'b1;
    dividend  = 32'd9;
    divisor   = 32'd3;
    @(posedge clock);
    #1;
    div_start = 1'b0;
    dividend  = 32'd1;
    divisor   = 32'd1;
    check("ign busy", div_busy, 1);
    wait_done(e);
    check("ign latency", e + 11, LATENCY);
    check("ign lo", lo, 32'd14);
    check("ign hi", hi, 32'd2);
    start_op(32'd9, 32'd3);
    check("b2b single done", div_done, 0);
    check("b2b busy", div_busy, 1);
    wait_done(e);
    check("b2b latency", e, LATENCY);
    check("b2b lo", lo, 32'd3);
    check("b2b hi", hi, 32'd0);
    exp_lo = 32'd3;
    exp_hi = 32'd0;

    // Reset mid-CALC aborts without a done pulse.
    start_op(32'd12345, 32'd7);
    repeat (15) begin
      @(posedge clock);
      #1;
    end
    #2 reset = 1'b0;
    #1;
    check("abort busy", div_busy, 0);
    check("abort done", div_done, 0);
    check("abort zero", div_zero, 0);
    check("abort hi", hi, 0);
    check("abort lo", lo, 0);
    @(posedge clock);
    #1;
    check("abort no done", div_done, 0);
    reset  = 1'b1;
    exp_lo = '0;
    exp_hi = '0;
    run_div(32'd20, 32'd4, "post-reset 20/4");
    check("20/4 lo const", lo, 32'd5);
    check("20/4 hi const", hi, 32'd0);

    // Randomized operands against the reference model.
    for (int i = 0; i < 20; i++) begin
      ra = (i % 7 == 3) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 3))
        0:       rb = $urandom;
        1:       rb = $urandom_range(1, 20);
        2:       rb = -$urandom_range(1, 20);
        default: rb = (i % 5 == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
      endcase
      run_div(ra, rb, $sformatf("rnd%0d %0h/%0h", i, ra, rb));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL declare parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL declare parameter STEP_W, default 6, width of iteration counter.
REQ-003 SHALL have port clock  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port div_start  input  1  control-unit request; sampled only in IDLE.
REQ-006 SHALL have port dividend  input  WIDTH  signed two's-complement numerator; sampled with div_start.
REQ-007 SHALL have port divisor  input  WIDTH  signed two's-complement denominator; sampled with div_start.
REQ-008 SHALL have port div_busy  output  1  registered; high while an operation is in progress.
REQ-009 SHALL have port div_done  output  1  registered one-cycle completion pulse to the control unit.
REQ-010 SHALL have port div_zero  output  1  registered divide-by-zero flag.
REQ-011 SHALL have port hi  output  WIDTH  registered remainder.
REQ-012 SHALL have port lo  output  WIDTH  registered quotient.

Function
REQ-013 SHALL implement states IDLE, CALC, FIX; the unit is the responder side of the control unit's div_start/div_done handshake.
REQ-014 IDLE: div_start=1 with divisor!=0 at edge E0 -> latch |dividend|, |divisor| and both sign bits, clear remainder accumulator, counter=0, div_busy=1, div_zero=0, go CALC.
REQ-015 IDLE: div_start=1 with divisor==0 at E0 -> div_zero=1, div_done=1 for one cycle, hi/lo unchanged, div_busy stays 0, stay IDLE.
REQ-016 CALC: one restoring shift-subtract iteration per edge, MSB first; after WIDTH iterations (edge E0+WIDTH) go FIX.
REQ-017 FIX at edge E0+WIDTH+1: lo = quotient negated iff dividend and divisor signs differ; hi = remainder carrying the dividend's sign; div_done=1, div_busy=0, go IDLE.
REQ-018 div_done SHALL be high for exactly one cycle per accepted request and 0 otherwise.
REQ-019 div_start while div_busy=1 SHALL be ignored; operands SHALL NOT be resampled mid-operation.
REQ-020 div_start asserted in the cycle div_done=1 SHALL be accepted (state already IDLE).
REQ-021 Magnitudes SHALL be formed at WIDTH+1 bits internally so -2^(WIDTH-1) is handled; results truncate to WIDTH bits.
REQ-022 -2^(WIDTH-1) / -1 SHALL yield lo=0x80000000, hi=0, div_zero=0 (wrap, no flag).
REQ-023 hi, lo SHALL hold their last values until the next successful completion.
REQ-024 div_zero SHALL stay set until the next accepted div_start.

Reset
REQ-025 reset=0 SHALL immediately, without clock: state=IDLE, div_busy=0, div_done=0, div_zero=0, hi=0, lo=0, counter=0.
REQ-026 reset asserted mid-CALC SHALL abort the operation with no div_done pulse; after release the unit accepts a new request on the first edge.

Verification
REQ-027 dividend=7, divisor=2 -> div_done exactly 33 edges after sampling edge, lo=3, hi=1.
REQ-028 dividend=-7, divisor=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; dividend=7, divisor=-2 -> lo=0xFFFFFFFD, hi=1.
REQ-029 divisor=0, dividend=5 -> next cycle div_done=1, div_zero=1, hi/lo keep prior values, div_busy never high.
REQ-030 dividend=0x80000000, divisor=0xFFFFFFFF -> lo=0x80000000, hi=0, div_zero=0.
REQ-031 start 100/7, pulse div_start again at iteration 10 with 9/3 -> result lo=14, hi=2, single div_done; then start 9/3 in the done cycle -> lo=3, hi=0.
REQ-032 assert reset at iteration 16 -> all outputs 0 asynchronously, no div_done; after release 20/4 -> lo=5, hi=0.
